// File: rtl/one_to_four_demux_reg.sv
// Registered 1-to-4 stream demultiplexer with a one-entry holding register per channel.
// Define DEMUX_CNT_EN to add per-channel accepted-word counters on port cnt.
module one_to_four_demux_reg #(
    parameter int W  = 8
`ifdef DEMUX_CNT_EN
    ,
    parameter int CW = 8
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   i,
    input  logic [1:0]     s,
    input  logic           i_valid,
    output logic           i_ready,
    output logic [4*W-1:0] y,
    output logic [3:0]     y_valid,
    input  logic [3:0]     y_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CW-1:0] cnt
`endif
);

    // Handshake: a word moves across an interface at a rising edge where valid & ready
    // are both high; the producer holds data/select stable while valid is high and not ready.
    logic [W-1:0] r_y [4];
    logic [3:0]   r_valid;
    logic         w_accept;
    logic [3:0]   w_load;

    // Ready looks only at the addressed channel, so one stalled lane never blocks the others.
    assign i_ready  = ~r_valid[s] | y_ready[s];
    assign w_accept = i_valid & i_ready;

    always_comb begin
        w_load = 4'b0000;
        if (w_accept) begin
            w_load[s] = 1'b1;
        end
    end

    // Load has priority over drain, which gives the bubble-free replace on a full ready channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_y[k]     <= i;
                    r_valid[k] <= 1'b1;
                end else if (r_valid[k] && y_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign y_valid = r_valid;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign y[g*W +: W] = r_y[g];
    end

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] r_cnt [4];

    // Counters wrap naturally at 2^CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign cnt[g*CW +: CW] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_one_to_four_demux_reg.sv
// Directed self-checking bench for one_to_four_demux_reg; covers the optional
// DEMUX_CNT_EN counters when that macro is defined.
module tb_one_to_four_demux_reg;

  localparam int W  = 8;
  localparam int CW = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   i;
  logic [1:0]     s;
  logic           i_valid;
  logic           i_ready;
  logic [4*W-1:0] y;
  logic [3:0]     y_valid;
  logic [3:0]     y_ready;
`ifdef DEMUX_CNT_EN
  logic [4*CW-1:0] cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entries are {channel, data}
  logic [W+1:0] exp_q[$];

  one_to_four_demux_reg #(
    .W(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i      (i),
    .s      (s),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .y      (y),
    .y_valid(y_valid),
    .y_ready(y_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt    (cnt)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after a rising edge, outputs read there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [1:0] ch);
    i       = d;
    s       = ch;
    i_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [W+1:0] e;
    rst     = 1'b1;
    i       = '0;
    s       = 2'd0;
    i_valid = 1'b0;
    y_ready = 4'b0000;
    step();
    step();
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_y", y, 32'h0);
    check("rst_i_ready", 32'(i_ready), 32'h1);
    rst = 1'b0;
    step();

    // single route to channel 2
    y_ready = 4'b1111;
    drive(8'hA5, 2'd2);
    check("route_i_ready", 32'(i_ready), 32'h1);
    step();
    idle();
    check("route_y_valid", 32'(y_valid), 32'h4);
    check("route_y2", 32'(y[23:16]), 32'hA5);
    step();
    check("route_drained", 32'(y_valid), 32'h0);

    // back-pressure on channel 1
    y_ready = 4'b0000;
    drive(8'h11, 2'd1);
    step();
    check("bp_first_valid", 32'(y_valid), 32'h2);
    drive(8'h22, 2'd1);
    check("bp_i_ready_low", 32'(i_ready), 32'h0);
    step();
    check("bp_hold_11", 32'(y[15:8]), 32'h11);
    y_ready[1] = 1'b1;
    #1;
    check("bp_i_ready_high", 32'(i_ready), 32'h1);
    step();
    idle();
    check("bp_no_bubble_valid", 32'(y_valid[1]), 32'h1);
    check("bp_new_22", 32'(y[15:8]), 32'h22);

    // independence: ch0 and ch1 stalled, stream into ch3
    y_ready = 4'b1000;
    drive(8'h5A, 2'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(W'(8'h30 + k), 2'd3);
      check($sformatf("ind_i_ready_%0d", k), 32'(i_ready), 32'h1);
      step();
      check($sformatf("ind_y3_%0d", k), 32'(y[31:24]), 32'(8'h30 + k));
      check($sformatf("ind_v3_%0d", k), 32'(y_valid[3]), 32'h1);
    end
    idle();
    step();
    check("ind_valid_after", 32'(y_valid), 32'h3);
    check("ind_ch0_kept", 32'(y[7:0]), 32'h5A);
    s = 2'd0;
    #1;
    check("ind_ch0_not_ready", 32'(i_ready), 32'h0);
    y_ready = 4'b1111;
    step();
    check("drain_all", 32'(y_valid), 32'h0);

    // round robin at full rate, scoreboarded
    for (int k = 0; k < 8; k++) begin
      drive(W'(k), 2'(k % 4));
      check($sformatf("rr_i_ready_%0d", k), 32'(i_ready), 32'h1);
      exp_q.push_back({2'(k % 4), W'(k)});
      step();
      e = exp_q.pop_front();
      check($sformatf("rr_valid_%0d", k), 32'(y_valid), 32'(4'b0001 << e[W+1:W]));
      check($sformatf("rr_data_%0d", k), 32'(y[e[W+1:W]*W +: W]), 32'(e[W-1:0]));
    end
    idle();
    step();
    check("rr_drained", 32'(y_valid), 32'h0);

    // asynchronous reset mid-stream
    y_ready = 4'b0000;
    drive(8'h77, 2'd1);
    step();
    drive(8'h88, 2'd3);
    step();
    check("pre_rst_valid", 32'(y_valid), 32'hA);
    drive(8'h99, 2'd1);
    check("pre_rst_i_ready", 32'(i_ready), 32'h0);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(y_valid), 32'h0);
    check("async_rst_y", y, 32'h0);
    check("async_rst_i_ready", 32'(i_ready), 32'h1);
    idle();
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(y_valid), 32'h0);

`ifdef DEMUX_CNT_EN
    check("cnt_rst", cnt, 32'h0);
    y_ready = 4'b1111;
    for (int k = 0; k < 256; k++) begin
      drive(W'(k), 2'd2);
      step();
      if (k == 254) check("cnt_255", 32'(cnt[23:16]), 32'd255);
    end
    idle();
    check("cnt_wrap", 32'(cnt[23:16]), 32'd0);
    check("cnt_others", {cnt[31:24], cnt[15:0]}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(W'(k), 2'd2);
      step();
    end
    idle();
    check("cnt_three", 32'(cnt[23:16]), 32'd3);
    check("cnt_others_end", {cnt[31:24], cnt[15:0]}, 32'h0);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/one_to_four_demux_reg.md
Name: one_to_four_demux_reg

Overview:
- Registered 1-to-4 stream demultiplexer: routes each input word to one of four output channels selected by a 2-bit select.
- Performs the inverse of the team's 4:1 mux trees.
- Each output channel has a one-entry holding register with a valid/ready handshake, so channels stall independently.
- Sits between a single producer and four consumers (e.g. per-lane sinks), one clock domain.

Parameters:
- W, 8, data width of input word and each output channel.
- CW, 8, width of per-channel transfer counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i  input  W  input data word.
- s  input  2  channel select for i; 0..3 maps to channel 0..3.
- i_valid  input  1  producer has a word on i/s.
- i_ready  output  1  block accepts i/s this cycle.
- y  output  4*W  channel data, channel k on y[k*W +: W].
- y_valid  output  4  channel k holds a valid word.
- y_ready  input  4  consumer k takes its word this cycle.
- cnt  output  4*CW  per-channel accepted-word counters, channel k on cnt[k*CW +: CW]. Present only with DEMUX_CNT_EN.

Behaviour:
- Reset:
  - rst=1 asynchronously clears y_valid to 4'b0000, y to 0, and cnt to 0.
  - i_ready reads 1 during and after reset (no channel full).
  - Reset mid-transfer discards all held words; no partial state survives.
- Transfer rules:
  - Input handshake: a word is accepted when i_valid & i_ready at a rising edge.
  - i_ready = ~y_valid[s] | y_ready[s]. This is combinational from s, y_valid and y_ready. It does not depend on i_valid.
  - Output handshake: channel k transfers when y_valid[k] & y_ready[k] at a rising edge.
- Latency:
  - An accepted word appears on channel s one clock after acceptance (y_valid[s]=1 after that edge).
  - No combinational path from i to y.
- Per-channel register update at each rising edge, channel k:
  - Load (accept with s==k): y[k] <= i, y_valid[k] <= 1.
  - Else drain (y_valid[k] & y_ready[k]): y_valid[k] <= 0. y[k] holds its last value.
  - Else hold.
- Boundary conditions:
  - Simultaneous drain and load on the same channel: the new word replaces the old, y_valid[k] stays 1, and there is no bubble. Sustained 1 word/clock per channel is possible.
  - Full channel, not ready: i_ready=0 for s==k. i, s and i_valid must be held stable by the producer until accepted. Other channels keep draining.
  - Channels never block each other. A full channel stalls only words addressed to it (head-of-line at the single input is inherent).
  - Handshake signals are don't-care while i_valid=0. No state changes.
  - y_ready on an empty channel has no effect.
  - s is sampled only on accept. s changing while i_valid=0 is harmless.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - cnt port exists. cnt[k] increments by 1 on each input accept with s==k.
  - Counters wrap modulo 2^CW (255 -> 0 for CW=8).
  - Reset clears them to 0.
  - Accept and wrap in the same edge yields 0.
- Undefined: cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 mid-stream with y_valid=4'b1010 -> y_valid=0, y=0, and i_ready=1 immediately (asynchronous, before the next clk edge).
- Single route: y_ready=4'b1111; i=8'hA5, s=2, i_valid pulse -> next cycle y_valid=4'b0100 and y[23:16]=8'hA5; one cycle later y_valid=0.
- Back-pressure: y_ready=0; send 8'h11 to ch1, then 8'h22 to ch1 -> the second word sees i_ready=0 and ch1 holds 8'h11. Raise y_ready[1] -> 8'h22 is accepted that edge and ch1 shows 8'h22 next cycle with no bubble.
- Independence: ch0 full and stalled (y_ready[0]=0); stream 8'h30..8'h33 to ch3 with y_ready[3]=1 -> all four words are accepted back-to-back and ch0 keeps its word.
- Round robin full rate: s=0,1,2,3,0,... with i=8'h00..8'h07 and all ready -> i_ready stays 1; each channel receives its words in order at 1-cycle latency.
- DEMUX_CNT_EN: send 256 words to ch2 -> cnt[2] wraps to 0, and cnt for the other channels stays 0. Send 3 more -> cnt[2]=3.
